// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier driving an external eight_bit_adder, with valid/ready on both sides.
// Optional ZERO_BYPASS_EN: a zero operand skips the iteration and yields product 0 on the accept edge.
module booth_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_op,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_over
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     m_r;
  logic [WIDTH-1:0]     q_r;
  logic [WIDTH-1:0]     acc_r;
  logic                 q_1_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   product_r;
  logic                 out_valid_r;
  logic                 in_ready_r;

  logic [WIDTH-1:0]     acc_next_s;
  logic [WIDTH-1:0]     q_next_s;
  logic                 last_step_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign product   = product_r;

  // Booth recoding of {Q[0], q_1} selects add, subtract or pass-through of M
  always_comb begin
    add_a = {WIDTH{1'b0}};
    add_b = {WIDTH{1'b0}};
    add_op = 1'b0;
    if (state_r == RUN) begin
      add_a = acc_r;
      case ({q_r[0], q_1_r})
        2'b10: begin
          add_b  = m_r;
          add_op = 1'b1;
        end
        2'b01: begin
          add_b  = m_r;
          add_op = 1'b0;
        end
        default: begin
          add_b  = {WIDTH{1'b0}};
          add_op = 1'b0;
        end
      endcase
    end else begin
      add_a  = {WIDTH{1'b0}};
      add_b  = {WIDTH{1'b0}};
      add_op = 1'b0;
    end
  end

  // Arithmetic shift right of {sum, Q}; sum^over restores the true sign when the adder overflowed
  always_comb begin
    acc_next_s  = {add_sum[WIDTH-1] ^ add_over, add_sum[WIDTH-1:1]};
    q_next_s    = {add_sum[0], q_r[WIDTH-1:1]};
    last_step_s = (cnt_r == CNT_W'(WIDTH - 1));
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      m_r         <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      q_1_r       <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      product_r   <= {(2*WIDTH){1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            m_r        <= mcand;
            q_r        <= mplier;
            acc_r      <= {WIDTH{1'b0}};
            q_1_r      <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
`ifdef ZERO_BYPASS_EN
            if ((mcand == {WIDTH{1'b0}}) || (mplier == {WIDTH{1'b0}})) begin
              product_r   <= {(2*WIDTH){1'b0}};
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              state_r <= RUN;
            end
`else
            state_r <= RUN;
`endif
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          q_r   <= q_next_s;
          q_1_r <= q_r[0];
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last_step_s) begin
            product_r   <= {acc_next_s, q_next_s};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (out_ready && out_valid_r) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq; includes a behavioural model of the eight_bit_adder it drives.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_op;
  logic [7:0]  add_sum;
  logic        add_over;

  int passed = 0;
  int total  = 0;

  booth_mult_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mcand(mcand), .mplier(mplier),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .add_a(add_a), .add_b(add_b), .add_op(add_op),
    .add_sum(add_sum), .add_over(add_over)
  );

  always #5 clk = ~clk;

  // 8-bit adder/subtractor with signed-overflow flag
  always_comb begin
    add_sum = add_op ? (add_a - add_b) : (add_a + add_b);
    if (add_op)
      add_over = (add_a[7] != add_b[7]) && (add_sum[7] != add_a[7]);
    else
      add_over = (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Accept a pair, expect out_valid after lat edges counting the accept edge, then handshake out
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int lat);
    logic early;
    early = 1'b0;
    mcand = a;
    mplier = b;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mcand = 8'h5A;
    mplier = 8'hA5;
    for (int i = 1; i < lat; i++) begin
      if (out_valid) early = 1'b1;
      @(posedge clk); #1;
    end
    check({tag, "_early_valid"}, early, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_product"}, product, exp);
    @(posedge clk); #1;
    check({tag, "_back_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    in_valid = 1'b0;
    mcand = 8'h00;
    mplier = 8'h00;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_product", product, 16'h0000);
    check("rst_add", {add_a, add_b, add_op}, 17'h00000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 3*5 with first Booth step observed and output backpressure
    out_ready = 1'b0;
    mcand = 8'd3;
    mplier = 8'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("p35_run_in_ready", in_ready, 1'b0);
    check("p35_step1_add_a", add_a, 8'h00);
    check("p35_step1_add_b", add_b, 8'h03);
    check("p35_step1_add_op", add_op, 1'b1);
    seen = 1'b0;
    for (int i = 1; i < 9; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("p35_early_valid", seen, 1'b0);
    check("p35_out_valid", out_valid, 1'b1);
    check("p35_product", product, 16'h000F);
    in_valid = 1'b1;
    mcand = 8'd9;
    mplier = 8'd9;
    repeat (5) @(posedge clk);
    #1;
    check("bp_product_held", product, 16'h000F);
    check("bp_out_valid_held", out_valid, 1'b1);
    check("bp_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);

    run_op("m128sq", 8'h80, 8'h80, 16'h4000, 9);
    run_op("m128x127", 8'h80, 8'h7F, 16'hC080, 9);
    run_op("p127xm1", 8'h7F, 8'hFF, 16'hFF81, 9);
    run_op("p127sq", 8'h7F, 8'h7F, 16'h3F01, 9);
    run_op("p100xm3", 8'd100, 8'hFD, 16'hFED4, 9);

    // Reset in the 4th RUN cycle of 7*9 aborts with no output pulse
    mcand = 8'd7;
    mplier = 8'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_product", product, 16'h0000);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_add", {add_a, add_b, add_op}, 17'h00000);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_pulse", seen, 1'b0);
    run_op("p2x2", 8'd2, 8'd2, 16'h0004, 9);

`ifdef ZERO_BYPASS_EN
    run_op("zero", 8'h00, 8'hB3, 16'h0000, 1);
`else
    run_op("zero", 8'h00, 8'hB3, 16'h0000, 9);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
